axil_mem_responder: RTL

- AXI4-Lite slave memory that terminates the cache's memory-side master port.
- Serves cache refill reads and evict/write-through writes from a word-organised byte-enabled array.
- Sits behind the cache controller in the cache testbench and integration top.
- Independent read and write channels, one outstanding transaction per channel, SLVERR on out-of-range addresses.

---
 rtl/axil_pkg.sv | 37 +++
 rtl/axil_mem_array.sv | 54 +++++
 rtl/axil_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared types and helpers for the AXI4-Lite memory responder.
//   resp_e        : AXI response codes used by this slave (OKAY / SLVERR)
//   wr_state_e    : write channel FSM states
//   rd_state_e    : read channel FSM states
//   LAT_W         : width of the per-channel latency down-counters
//   addr_in_range : true when a byte address falls inside the array
// ---------------------------------------------------------------------------
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  localparam int LAT_W = 4;

  // Addresses are zero-extended to 64 bits so any ADDR_WIDTH up to 64 works.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] mem_bytes);
    return addr < mem_bytes;
  endfunction

endpackage

// File: rtl/axil_mem_array.sv
// ---------------------------------------------------------------------------
// axil_mem_array
// Word-organised byte-enable RAM with one synchronous write port and one
// synchronous read port. A read and a write to the same word on the same
// edge return the pre-write contents.
// Ports:
//   clk      in  clock
//   wr_en    in  write enable
//   wr_idx   in  word index for the write
//   wr_data  in  write data
//   wr_strb  in  byte enables (one per byte of wr_data)
//   rd_en    in  read enable; rd_data updates on the edge it is sampled high
//   rd_idx   in  word index for the read
//   rd_data  out registered read data, held until the next rd_en
// ---------------------------------------------------------------------------
module axil_mem_array #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_BYTES  = 4096,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int WORDS      = MEM_BYTES / STRB_W,
  localparam int IDX_W      = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_W-1:0]     wr_strb,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  // NOTE: non-blocking assignments here are what give read-before-write on a
  //       same-word collision, with no ordering dependence between statements.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axil_mem_responder.sv
// ---------------------------------------------------------------------------
// axil_mem_responder
// AXI4-Lite slave memory terminating the cache's memory-side master port.
// Independent read and write channels, one outstanding transaction each,
// SLVERR for addresses at or above MEM_BYTES.
//
// Build option: define AXIL_MEM_LATENCY_EN to insert RD_LATENCY / WR_LATENCY
// extra wait cycles before each response (W_WAIT / R_WAIT states). Without
// it both channels respond one cycle after acceptance.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axil_aw{valid,ready,addr}    write address channel
//   s_axil_w{valid,ready,data,strb} write data channel
//   s_axil_b{valid,ready,resp}     write response channel
//   s_axil_ar{valid,ready,addr}    read address channel
//   s_axil_r{valid,ready,data,resp} read data channel
// ---------------------------------------------------------------------------
module axil_mem_responder
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  output logic [1:0]              s_axil_bresp,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_BYTES / STRB_W);

  // Elaboration-time parameter sanity checks.
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axil_mem_responder: DATA_WIDTH must be 32 or 64");
  end
  if ((MEM_BYTES & (MEM_BYTES - 1)) != 0 || MEM_BYTES < STRB_W) begin : g_bad_mem_bytes
    $error("axil_mem_responder: MEM_BYTES must be a power of 2 and at least one word");
  end
  if (RD_LATENCY < 0 || RD_LATENCY > 15 || WR_LATENCY < 0 || WR_LATENCY > 15) begin : g_bad_latency
    $error("axil_mem_responder: RD_LATENCY/WR_LATENCY must be in 0..15");
  end

  // -------------------------------------------------------------------------
  // Write channel state
  // -------------------------------------------------------------------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  resp_e                 bresp_q, bresp_d;
`ifdef AXIL_MEM_LATENCY_EN
  logic [LAT_W-1:0]      wr_cnt_q, wr_cnt_d;
`endif

  logic                  aw_fire, w_fire, wr_commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr_cur;
  logic [DATA_WIDTH-1:0] wr_data_cur;
  logic [STRB_W-1:0]     wr_strb_cur;
  logic                  mem_we;

  // -------------------------------------------------------------------------
  // Read channel state
  // -------------------------------------------------------------------------
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  resp_e                 rresp_q, rresp_d;
`ifdef AXIL_MEM_LATENCY_EN
  logic [LAT_W-1:0]      rd_cnt_q, rd_cnt_d;
`endif

  logic                  ar_fire, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Readies are registered, so they never depend on the incoming valids.
  assign aw_fire = s_axil_awvalid && awready_q;
  assign w_fire  = s_axil_wvalid  && wready_q;
  assign ar_fire = s_axil_arvalid && arready_q;

  // The beat being committed is the held copy if present, otherwise the one
  // arriving this cycle (covers AW/W landing on the same edge).
  assign wr_addr_cur = aw_held_q ? awaddr_q : s_axil_awaddr;
  assign wr_data_cur = w_held_q  ? wdata_q  : s_axil_wdata;
  assign wr_strb_cur = w_held_q  ? wstrb_q  : s_axil_wstrb;
  assign wr_ok       = addr_in_range(64'(wr_addr_cur), 64'(MEM_BYTES));
  assign rd_ok       = addr_in_range(64'(s_axil_araddr), 64'(MEM_BYTES));

  // -------------------------------------------------------------------------
  // Write FSM next state
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  //       path through the case statement can infer a latch.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
`ifdef AXIL_MEM_LATENCY_EN
    wr_cnt_d   = wr_cnt_q;
`endif

    case (wr_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axil_awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
`ifdef AXIL_MEM_LATENCY_EN
          if (WR_LATENCY != 0) begin
            wr_state_d = W_WAIT;
            wr_cnt_d   = LAT_W'(WR_LATENCY);
          end else begin
            wr_commit = 1'b1;
          end
`else
          wr_commit = 1'b1;
`endif
        end
      end

      W_WAIT: begin
`ifdef AXIL_MEM_LATENCY_EN
        // Both beats are held here; commit as the counter reaches zero.
        if (wr_cnt_q == LAT_W'(1)) begin
          wr_commit = 1'b1;
        end
        wr_cnt_d = wr_cnt_q - LAT_W'(1);
`else
        wr_state_d = W_IDLE;
`endif
      end

      W_RESP: begin
        if (s_axil_bready) begin
          wr_state_d = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b0;
          bresp_d    = OKAY;
        end
      end

      default: wr_state_d = W_IDLE;
    endcase

    if (wr_commit) begin
      wr_state_d = W_RESP;
      bvalid_d   = 1'b1;
      bresp_d    = wr_ok ? OKAY : SLVERR;
    end

    awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
  end

  // Out-of-range writes are answered with SLVERR and never reach the array.
  assign mem_we = wr_commit && wr_ok;

  // -------------------------------------------------------------------------
  // Read FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
`ifdef AXIL_MEM_LATENCY_EN
    rd_cnt_d   = rd_cnt_q;
`endif

    case (rd_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rresp_d = rd_ok ? OKAY : SLVERR;
`ifdef AXIL_MEM_LATENCY_EN
          if (RD_LATENCY != 0) begin
            rd_state_d = R_WAIT;
            rd_cnt_d   = LAT_W'(RD_LATENCY);
          end else begin
            rd_state_d = R_DATA;
            rvalid_d   = 1'b1;
          end
`else
          rd_state_d = R_DATA;
          rvalid_d   = 1'b1;
`endif
        end
      end

      R_WAIT: begin
`ifdef AXIL_MEM_LATENCY_EN
        if (rd_cnt_q == LAT_W'(1)) begin
          rd_state_d = R_DATA;
          rvalid_d   = 1'b1;
        end
        rd_cnt_d = rd_cnt_q - LAT_W'(1);
`else
        rd_state_d = R_IDLE;
`endif
      end

      R_DATA: begin
        if (s_axil_rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          rresp_d    = OKAY;
        end
      end

      default: rd_state_d = R_IDLE;
    endcase

    arready_d = (rd_state_d == R_IDLE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
`ifdef AXIL_MEM_LATENCY_EN
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
`ifdef AXIL_MEM_LATENCY_EN
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Storage: read data is captured on the AR acceptance edge and held by the
  // array's read register until the next accepted AR.
  // -------------------------------------------------------------------------
  axil_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_idx  (wr_addr_cur[OFF_W +: IDX_W]),
    .wr_data (wr_data_cur),
    .wr_strb (wr_strb_cur),
    .rd_en   (ar_fire),
    .rd_idx  (s_axil_araddr[OFF_W +: IDX_W]),
    .rd_data (mem_rdata)
  );

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  // The array read register is not reset; masking keeps rdata at zero in
  // reset, while waiting, and for SLVERR responses.
  assign s_axil_rdata   = (rvalid_q && rresp_q == OKAY) ? mem_rdata : '0;

endmodule
